button_debounce: RTL and testbench
==================================

# button_debounce

Per-button synchroniser, debouncer and edge detector sitting between the raw board push-buttons and the button state machine in the button display top level. Each raw button input is synchronised into `iClk`, filtered until stable for a programmable number of cycles, and presented as a clean level plus single-cycle press/release pulses. The button FSM consumes the press pulses instead of raw `iBtns`. An optional auto-repeat feature regenerates press pulses while a button is held.

## Interface
- `NUM_BTNS`, 4, number of independent button channels
- `DEBOUNCE_CYCLES`, 500000, stable cycles required before a level change is accepted (≥1; 5 ms at 100 MHz)
- `REPEAT_DELAY`, 50000000, cycles from press pulse to first repeat pulse (auto-repeat only, ≥1)
- `REPEAT_PERIOD`, 10000000, cycles between subsequent repeat pulses (auto-repeat only, ≥1)
- `iClk`  in  1  system clock; one clock domain, all logic on rising edge
- `iRst_n`  in  1  reset, synchronous, active-low
- `iBtns`  in  NUM_BTNS  raw asynchronous button inputs, 1 = pressed
- `oLevel`  out  NUM_BTNS  debounced button level
- `oPress`  out  NUM_BTNS  one-cycle pulse per accepted press (plus repeats if enabled)
- `oRelease`  out  NUM_BTNS  one-cycle pulse per accepted release

## Operation
- Channels fully independent; any combination of bits may pulse in the same cycle.
- Per channel: 2-flop synchroniser → stable-level register `lvl` → counter `cnt` of width clog2(DEBOUNCE_CYCLES).
- Each cycle, with `s` = synchroniser output:
  - `s == lvl`: `cnt` ← 0.
  - `s != lvl` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` ← `cnt`+1.
  - `s != lvl` and `cnt == DEBOUNCE_CYCLES-1`: `lvl` ← `s`, `cnt` ← 0, and `oPress` (0→1) or `oRelease` (1→0) is registered high for the next cycle.
- Any bounce back to `lvl` before acceptance clears `cnt`, so the count restarts from 0.
- `oLevel` = `lvl`. `oPress` and `oRelease` are registered, never combinational from `iBtns`.
- Per-channel state: IDLE (`lvl`=0), ARMED (`lvl`=0, counting), HELD (`lvl`=1), DISARMING (`lvl`=1, counting).
- Reset (`iRst_n`=0 at an edge): synchronisers, `lvl`, `cnt`, repeat counters and all outputs ← 0. Reset mid-count discards the count.
- A button held through reset produces a normal `oPress` after debounce once reset is released.

## Timing
- Sampling edge k is the first edge at which the changed `iBtns` is captured.
- `oLevel` changes, and the corresponding pulse rises, at edge k+DEBOUNCE_CYCLES+1. Latency is DEBOUNCE_CYCLES+2 edges, counting k as edge 1.
- Pulses are exactly one cycle wide.
- `oPress` and `oRelease` of the same channel are never high together.
- The input must be stable for at least DEBOUNCE_CYCLES consecutive synchronised samples to be accepted.

## Configuration
- Macro: `BUTTON_DEBOUNCE_AUTOREPEAT_EN`.
- Defined: per-channel repeat counter runs while `lvl`=1.
  - For a press pulse high in cycle P, extra `oPress` pulses occur in cycles P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_PERIOD, P+REPEAT_DELAY+2·REPEAT_PERIOD, and so on.
  - The repeat counter clears on release acceptance or reset. Repeats never generate `oRelease`.
- Undefined: no repeat logic is synthesised, exactly one `oPress` per accepted press, and REPEAT_* parameters are ignored.

## Structure
- Shared package `button_pkg`: default `NUM_BTNS`, default debounce/repeat cycle constants, and the clog2-based counter-width function.
- Sub-module `button_debounce_ch`: single-channel synchroniser, debouncer, edge detector and optional repeat counter. The top level generates `NUM_BTNS` instances.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, NUM_BTNS=4.
- Reset with `iBtns`=0 → `oLevel`=0, `oPress`=`oRelease`=0 during reset and after release.
- `iBtns[0]` 0→1 sampled at edge k and held → `oLevel[0]`=1 and `oPress[0]` pulse at edge k+5, one cycle wide; `oRelease` stays 0.
- `iBtns[1]` high 3 cycles, low 1 cycle, high 3 cycles → no `oLevel[1]` change and no pulses; a subsequent hold of ≥4 cycles is accepted with a fresh full count.
- `iBtns`=4'b1010 applied simultaneously, then 4'b0000 → `oPress`=4'b1010 in one cycle, later `oRelease`=4'b1010 in one cycle.
- `iBtns[2]` held through reset deassertion → `oPress[2]` fires DEBOUNCE_CYCLES+2 edges after the first post-reset sampling edge.
- Auto-repeat build, `iBtns[3]` held 60 cycles past press pulse P → `oPress[3]` in cycles P, P+20, P+28, P+36, P+44, P+52; no repeats after release; non-repeat build sees only P.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants, per-channel state encoding and counter sizing helpers for button_debounce.
package button_pkg;

   localparam int NUM_BTNS_DEF        = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 500000;
   localparam int REPEAT_DELAY_DEF    = 50000000;
   localparam int REPEAT_PERIOD_DEF   = 10000000;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_ARMED     = 2'b01,
      ST_HELD      = 2'b10,
      ST_DISARMING = 2'b11
   } deb_state_e;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter, press/release pulses.
// Auto-repeat of press pulses is built only when BUTTON_DEBOUNCE_AUTOREPEAT_EN is defined.
module button_debounce_ch
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level,
   output logic press,
   output logic rel
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_check
      $error("button_debounce_ch: cycle parameters must be >= 1");
   end

   logic [1:0]       sync_q;
   deb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;
   logic             lvl;
   logic             s;
   logic             accept_press;
   logic             rpt_fire;

   assign s   = sync_q[1];
   assign lvl = (state_q == ST_HELD) || (state_q == ST_DISARMING);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      accept_press = 1'b0;
      rel_d        = 1'b0;
      if (s == lvl) begin
         cnt_d   = '0;
         state_d = lvl ? ST_HELD : ST_IDLE;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         cnt_d        = '0;
         state_d      = s ? ST_HELD : ST_IDLE;
         accept_press = s;
         rel_d        = ~s;
      end else begin
         cnt_d   = cnt_q + 1'b1;
         state_d = lvl ? ST_DISARMING : ST_ARMED;
      end
      press_d = accept_press | rpt_fire;
   end

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
   localparam int RPT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_first_q, rpt_first_d;

   // The first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; a release being accepted wins.
   always_comb begin
      rpt_cnt_d   = rpt_cnt_q;
      rpt_first_d = rpt_first_q;
      rpt_fire    = 1'b0;
      if (!lvl || rel_d) begin
         rpt_cnt_d   = '0;
         rpt_first_d = 1'b1;
      end else if (rpt_cnt_q == (rpt_first_q ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1))) begin
         rpt_cnt_d   = '0;
         rpt_first_d = 1'b0;
         rpt_fire    = 1'b1;
      end else begin
         rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rpt_cnt_q   <= '0;
         rpt_first_q <= 1'b1;
      end else begin
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_first_q <= rpt_first_d;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q  <= 2'b00;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign level = lvl;
   assign press = press_q;
   assign rel   = rel_q;

endmodule

// File: rtl/button_debounce.sv
// Array of independent button debouncers feeding the button FSM with clean levels and pulses.
// Optional auto-repeat is enabled by defining BUTTON_DEBOUNCE_AUTOREPEAT_EN.
module button_debounce
   import button_pkg::*;
#(
   parameter int NUM_BTNS        = NUM_BTNS_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic                iClk,
   input  logic                iRst_n,
   input  logic [NUM_BTNS-1:0] iBtns,
   output logic [NUM_BTNS-1:0] oLevel,
   output logic [NUM_BTNS-1:0] oPress,
   output logic [NUM_BTNS-1:0] oRelease
);

   for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_ch
      button_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk   (iClk),
         .rst_n (iRst_n),
         .btn   (iBtns[gi]),
         .level (oLevel[gi]),
         .press (oPress[gi]),
         .rel   (oRelease[gi])
      );
   end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed scenarios plus random bouncing, against a window-based model.
module tb_button_debounce;

   localparam int NB = 4;
   localparam int DC = 4;
   localparam int RD = 20;
   localparam int RP = 8;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NB-1:0] btns;
   logic [NB-1:0] level, press, rel;

   always #5 clk = ~clk;

   button_debounce #(
      .NUM_BTNS        (NB),
      .DEBOUNCE_CYCLES (DC),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .iClk     (clk),
      .iRst_n   (rst_n),
      .iBtns    (btns),
      .oLevel   (level),
      .oPress   (press),
      .oRelease (rel)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Model: a level flips once the last DC synchronised samples all disagree with it.
   int            edge_n = 0;
   logic [NB-1:0] raw_n1 = '0, raw_n2 = '0;
   logic [NB-1:0] win [DC];
   logic [NB-1:0] m_lvl = '0, e_press = '0, e_rel = '0;
   int            press_edge [NB];

   task automatic model_edge(input logic r, input logic [NB-1:0] b);
      logic [NB-1:0] s;
      logic          all_diff;
      int            d;
      edge_n++;
      if (!r) begin
         raw_n1 = '0; raw_n2 = '0;
         for (int i = 0; i < DC; i++) win[i] = '0;
         m_lvl = '0; e_press = '0; e_rel = '0;
         return;
      end
      s      = raw_n2;
      raw_n2 = raw_n1;
      raw_n1 = b;
      for (int i = DC - 1; i > 0; i--) win[i] = win[i-1];
      win[0]  = s;
      e_press = '0;
      e_rel   = '0;
      for (int ch = 0; ch < NB; ch++) begin
         all_diff = 1'b1;
         for (int i = 0; i < DC; i++)
            if (win[i][ch] == m_lvl[ch]) all_diff = 1'b0;
         if (all_diff) begin
            m_lvl[ch] = ~m_lvl[ch];
            if (m_lvl[ch]) begin
               e_press[ch]    = 1'b1;
               press_edge[ch] = edge_n;
            end else begin
               e_rel[ch] = 1'b1;
            end
         end else if (AR && m_lvl[ch]) begin
            d = edge_n - press_edge[ch];
            if (d >= RD && ((d - RD) % RP) == 0) e_press[ch] = 1'b1;
         end
      end
   endtask

   task automatic step(input logic r, input logic [NB-1:0] b);
      rst_n = r;
      btns  = b;
      @(posedge clk);
      model_edge(r, b);
      @(negedge clk);
      n_assert++;
      assert (level === m_lvl) else begin
         n_fail++;
         $error("FAIL level edge %0d: got %b expected %b", edge_n, level, m_lvl);
      end
      n_assert++;
      assert (press === e_press) else begin
         n_fail++;
         $error("FAIL press edge %0d: got %b expected %b", edge_n, press, e_press);
      end
      n_assert++;
      assert (rel === e_rel) else begin
         n_fail++;
         $error("FAIL release edge %0d: got %b expected %b", edge_n, rel, e_rel);
      end
      n_assert++;
      assert ((press & rel) === '0) else begin
         n_fail++;
         $error("FAIL press_rel_overlap edge %0d: got %b expected 0000", edge_n, press & rel);
      end
      $display("edge %0d rst_n=%b btns=%b level=%b press=%b release=%b", edge_n, r, b, level, press, rel);
   endtask

   int            k;
   int            found;
   int            cnt3;
   logic [NB-1:0] press_or, rel_or;
   logic [NB-1:0] cur;

   initial begin
      rst_n = 1'b0;
      btns  = '0;
      for (int i = 0; i < NB; i++) press_edge[i] = 0;
      for (int i = 0; i < DC; i++) win[i] = '0;

      // Reset and idle
      repeat (3) step(1'b0, 4'b0000);
      repeat (3) step(1'b1, 4'b0000);

      // Single press on channel 0: latency check
      step(1'b1, 4'b0001);
      k     = edge_n;
      found = -1;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 4'b0001);
         if (press[0] && found < 0) found = edge_n;
      end
      n_assert++;
      assert (found === k + DC + 1) else begin
         n_fail++;
         $error("FAIL press0_latency: got edge %0d expected edge %0d", found, k + DC + 1);
      end
      repeat (10) step(1'b1, 4'b0000);

      // Channel 1 bounce: 3 high, 1 low, 3 high must be rejected
      repeat (3) step(1'b1, 4'b0010);
      step(1'b1, 4'b0000);
      repeat (3) step(1'b1, 4'b0010);
      repeat (4) step(1'b1, 4'b0000);
      n_assert++;
      assert (level[1] === 1'b0) else begin
         n_fail++;
         $error("FAIL bounce_reject: got level1 %b expected 0", level[1]);
      end
      repeat (8) step(1'b1, 4'b0010);
      n_assert++;
      assert (level[1] === 1'b1) else begin
         n_fail++;
         $error("FAIL bounce_then_hold: got level1 %b expected 1", level[1]);
      end
      repeat (10) step(1'b1, 4'b0000);

      // Simultaneous press and release of channels 1 and 3
      press_or = '0;
      rel_or   = '0;
      repeat (10) begin
         step(1'b1, 4'b1010);
         press_or |= press;
      end
      repeat (10) begin
         step(1'b1, 4'b0000);
         rel_or |= rel;
      end
      n_assert++;
      assert (press_or === 4'b1010) else begin
         n_fail++;
         $error("FAIL multi_press: got %b expected 1010", press_or);
      end
      n_assert++;
      assert (rel_or === 4'b1010) else begin
         n_fail++;
         $error("FAIL multi_release: got %b expected 1010", rel_or);
      end

      // Channel 2 held through reset
      repeat (3) step(1'b0, 4'b0100);
      k     = edge_n + 1;
      found = -1;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 4'b0100);
         if (press[2] && found < 0) found = edge_n;
      end
      n_assert++;
      assert (found === k + DC + 1) else begin
         n_fail++;
         $error("FAIL held_through_reset: got edge %0d expected edge %0d", found, k + DC + 1);
      end
      repeat (10) step(1'b1, 4'b0000);

      // Channel 3 long hold: repeat pulses only in the auto-repeat build
      found = -1;
      for (int i = 0; i < 12 && found < 0; i++) begin
         step(1'b1, 4'b1000);
         if (press[3]) found = edge_n;
      end
      cnt3 = (found >= 0) ? 1 : 0;
      for (int i = 1; i < 60; i++) begin
         step(1'b1, 4'b1000);
         if (press[3]) cnt3++;
      end
      n_assert++;
      assert (cnt3 === (AR ? 6 : 1)) else begin
         n_fail++;
         $error("FAIL repeat_count: got %0d expected %0d", cnt3, AR ? 6 : 1);
      end
      repeat (30) step(1'b1, 4'b0000);
      n_assert++;
      assert (level[3] === 1'b0) else begin
         n_fail++;
         $error("FAIL long_hold_release: got level3 %b expected 0", level[3]);
      end

      // Random bouncing with occasional resets
      cur = '0;
      for (int i = 0; i < 600; i++) begin
         for (int ch = 0; ch < NB; ch++)
            if ($urandom_range(0, 5) == 0) cur[ch] = ~cur[ch];
         step(($urandom_range(0, 150) == 0) ? 1'b0 : 1'b1, cur);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
